// File: rtl/ripple_count_pkg.sv
// rtl/ripple_count_pkg.sv - shared types and default sizes for the ripple counter capture path
package ripple_count_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam int DEF_CNT_W    = 4;
    localparam int DEF_EXT_W    = 8;
    localparam int DEF_STABLE_N = 2;
    localparam int GLITCH_W     = 8;
    localparam int SYNC_DEPTH   = 2;

endpackage

// File: rtl/sync2_bus.sv
// rtl/sync2_bus.sv - parameterised two-flop bus synchronizer
module sync2_bus #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/ripple_count_capture.sv
// rtl/ripple_count_capture.sv - ripple count filter/extender with event output; RCC_GLITCH_CNT_EN adds glitch_cnt
module ripple_count_capture
    import ripple_count_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int EXT_W    = DEF_EXT_W,
    parameter int STABLE_N = DEF_STABLE_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count_in,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_wrap,
    output logic [EXT_W-1:0] ext_count,
    output logic             overrun
`ifdef RCC_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int               SC_W      = $clog2(STABLE_N + 1);
    localparam logic [SC_W-1:0]  STAB_LAST = SC_W'(STABLE_N - 1);
    localparam logic [SC_W-1:0]  STAB_ONE  = SC_W'(1);
    localparam int               PAD_W     = EXT_W - CNT_W;
    localparam logic [1:0]       FILL_DONE = 2'(SYNC_DEPTH);

    logic [CNT_W-1:0] s2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] last_acc;
    logic [CNT_W-1:0] last_acc_nxt;
    logic [CNT_W-1:0] cand;
    logic [CNT_W-1:0] cand_nxt;
    logic [SC_W-1:0]  stab_cnt;
    logic [SC_W-1:0]  stab_nxt;
    logic [1:0]       fill;
    logic             init_load;
    logic             accept;
    logic [CNT_W-1:0] delta;

    sync2_bus #(.W(CNT_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (count_in),
        .q   (s2)
    );

    assign delta = cand - last_acc;

    always_comb begin
        state_nxt    = state;
        cand_nxt     = cand;
        stab_nxt     = stab_cnt;
        last_acc_nxt = last_acc;
        init_load    = 1'b0;
        accept       = 1'b0;
        case (state)
            ST_INIT: begin
                // s2 still carries reset zeros until the synchronizer refills
                if (fill == FILL_DONE) begin
                    if (s2 == cand) begin
                        if (stab_cnt == STAB_LAST) begin
                            init_load    = 1'b1;
                            last_acc_nxt = s2;
                            state_nxt    = ST_TRACK;
                        end else begin
                            stab_nxt = stab_cnt + STAB_ONE;
                        end
                    end else begin
                        cand_nxt = s2;
                        stab_nxt = STAB_ONE;
                    end
                end
            end
            ST_TRACK: begin
                if (s2 != last_acc) begin
                    cand_nxt  = s2;
                    stab_nxt  = STAB_ONE;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (s2 == cand) begin
                    if (stab_cnt == STAB_LAST) begin
                        accept       = 1'b1;
                        last_acc_nxt = cand;
                        state_nxt    = ST_TRACK;
                    end else begin
                        stab_nxt = stab_cnt + STAB_ONE;
                    end
                end else if (s2 == last_acc) begin
                    state_nxt = ST_TRACK;
                end else begin
                    cand_nxt = s2;
                    stab_nxt = STAB_ONE;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            cand      <= '0;
            stab_cnt  <= '0;
            last_acc  <= '0;
            fill      <= '0;
            ext_count <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_wrap  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            stab_cnt <= stab_nxt;
            last_acc <= last_acc_nxt;
            if (fill != FILL_DONE) begin
                fill <= fill + 2'd1;
            end

            // clr realigns to the freshest accepted value, including one landing now
            if (clr) begin
                ext_count <= {{PAD_W{1'b0}}, last_acc_nxt};
            end else if (init_load) begin
                ext_count <= {{PAD_W{1'b0}}, s2};
            end else if (accept) begin
                ext_count <= ext_count + {{PAD_W{1'b0}}, delta};
            end

            if (accept) begin
                out_valid <= 1'b1;
                out_count <= cand;
                out_wrap  <= (cand < last_acc);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (clr) begin
                overrun <= 1'b0;
            end else if (accept && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef RCC_GLITCH_CNT_EN
    // Covers both a rejected transient and a candidate replacement
    logic glitch_evt;
    assign glitch_evt = (state == ST_SETTLE) && (s2 != cand);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            glitch_cnt <= '0;
        end else if (glitch_evt && (glitch_cnt != {GLITCH_W{1'b1}})) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
        end
    end
`endif

endmodule
